// File: rtl/alu_mc.sv
// Multi-cycle ALU: valid/ready in and out, one-hot ALU_CTL opcodes, 1-cycle simple ops,
// WIDTH-cycle restoring DIV/REM and optional WIDTH-cycle shift-add MUL/MULH.
`ifndef ALU_CTL_ADD
`define ALU_CTL_ADD  16'h0001
`define ALU_CTL_SUB  16'h0002
`define ALU_CTL_SLT  16'h0004
`define ALU_CTL_SLTU 16'h0008
`define ALU_CTL_SLL  16'h0010
`define ALU_CTL_SRL  16'h0020
`define ALU_CTL_SRA  16'h0040
`define ALU_CTL_AND  16'h0080
`define ALU_CTL_OR   16'h0100
`define ALU_CTL_XOR  16'h0200
`define ALU_CTL_NOT  16'h0400
`define ALU_CTL_MUL  16'h0800
`define ALU_CTL_MULH 16'h1000
`define ALU_CTL_DIV  16'h2000
`define ALU_CTL_REM  16'h4000
`endif

module alu_mc #(
    parameter int WIDTH    = 32,
    parameter int MUL_ITER = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [15:0]      ctl,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] res,
    output logic             err,
    output logic             busy
);
    localparam int SW = $clog2(WIDTH);
    localparam logic [1:0] K_MUL = 2'd0, K_MULH = 2'd1, K_DIV = 2'd2, K_REM = 2'd3;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_nxt;

    logic               rdy_en, accept, onehot, iter;
    logic [1:0]         kind, op_q;
    logic [SW-1:0]      cnt;
    logic [WIDTH-1:0]   sc_res, res_q, a_q, b_q, a_nxt, fin_res;
    logic [2*WIDTH-1:0] acc, mcand, acc_nxt, mul_full, prod_fix;
    logic [WIDTH-1:0]   abs1, abs2;
    logic [WIDTH:0]     rem_sh, rem_diff;
    logic               err_q, neg_q, ge;
    logic [SW-1:0]      sh;

    assign onehot  = (ctl != 16'h0) && ((ctl & (ctl - 16'h1)) == 16'h0);
    assign in_rdy  = rdy_en && ((state == IDLE) || (state == DONE && out_rdy));
    assign accept  = in_vld && in_rdy;
    assign out_vld = (state == DONE);
    assign busy    = (state == BUSY);
    assign res     = res_q;
    assign err     = err_q;
    assign sh      = op2[SW-1:0];
    assign abs1    = op1[WIDTH-1] ? -op1 : op1;
    assign abs2    = op2[WIDTH-1] ? -op2 : op2;

    // Sign-extended operands make the low 2*WIDTH bits equal the signed product.
    assign mul_full = {{WIDTH{op1[WIDTH-1]}}, op1} * {{WIDTH{op2[WIDTH-1]}}, op2};

    always_comb begin
        kind = K_MUL;
        iter = 1'b0;
        case (ctl)
            `ALU_CTL_MUL:  begin kind = K_MUL;  iter = (MUL_ITER != 0); end
            `ALU_CTL_MULH: begin kind = K_MULH; iter = (MUL_ITER != 0); end
            `ALU_CTL_DIV:  begin kind = K_DIV;  iter = (op2 != '0); end
            `ALU_CTL_REM:  begin kind = K_REM;  iter = (op2 != '0); end
            default: ;
        endcase
    end

    always_comb begin
        sc_res = '0;
        case (ctl)
            `ALU_CTL_ADD:  sc_res = op1 + op2;
            `ALU_CTL_SUB:  sc_res = op1 - op2;
            `ALU_CTL_SLT:  sc_res = {{(WIDTH-1){1'b0}}, $signed(op1) < $signed(op2)};
            `ALU_CTL_SLTU: sc_res = {{(WIDTH-1){1'b0}}, op1 < op2};
            `ALU_CTL_SLL:  sc_res = op1 << sh;
            `ALU_CTL_SRL:  sc_res = op1 >> sh;
            `ALU_CTL_SRA:  sc_res = $signed(op1) >>> sh;
            `ALU_CTL_AND:  sc_res = op1 & op2;
            `ALU_CTL_OR:   sc_res = op1 | op2;
            `ALU_CTL_XOR:  sc_res = op1 ^ op2;
            `ALU_CTL_NOT:  sc_res = ~op1;
            `ALU_CTL_MUL:  sc_res = mul_full[WIDTH-1:0];
            `ALU_CTL_MULH: sc_res = mul_full[2*WIDTH-1:WIDTH];
            `ALU_CTL_DIV:  sc_res = '1;
            `ALU_CTL_REM:  sc_res = op1;
            default:       sc_res = '0;
        endcase
    end

    // One iteration step: restoring divide (acc low = remainder, a_q = quotient)
    // or shift-add multiply (a_q = multiplier, mcand shifts left).
    always_comb begin
        rem_sh   = {acc[WIDTH-1:0], a_q[WIDTH-1]};
        rem_diff = rem_sh - {1'b0, b_q};
        ge       = (rem_sh >= {1'b0, b_q});
        acc_nxt  = acc;
        a_nxt    = a_q;
        if (op_q == K_DIV || op_q == K_REM) begin
            acc_nxt = {{WIDTH{1'b0}}, ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]};
            a_nxt   = {a_q[WIDTH-2:0], ge};
        end else begin
            acc_nxt = acc + (a_q[0] ? mcand : '0);
            a_nxt   = a_q >> 1;
        end
        prod_fix = neg_q ? -acc_nxt : acc_nxt;
        case (op_q)
            K_MUL:   fin_res = acc_nxt[WIDTH-1:0];
            K_MULH:  fin_res = prod_fix[2*WIDTH-1:WIDTH];
            K_DIV:   fin_res = a_nxt;
            default: fin_res = acc_nxt[WIDTH-1:0];
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = iter ? BUSY : DONE;
            BUSY: if (cnt == '0) state_nxt = DONE;
            DONE: begin
                if (accept)       state_nxt = iter ? BUSY : DONE;
                else if (out_rdy) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            rdy_en <= 1'b0;
            res_q  <= '0;
            err_q  <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= K_MUL;
            neg_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            rdy_en <= 1'b1;
            if (accept) begin
                op_q <= kind;
                cnt  <= SW'(WIDTH-1);
                acc  <= '0;
                if (iter) begin
                    if (kind == K_MULH) begin
                        a_q   <= abs1;
                        mcand <= {{WIDTH{1'b0}}, abs2};
                        neg_q <= op1[WIDTH-1] ^ op2[WIDTH-1];
                    end else begin
                        a_q   <= op1;
                        mcand <= {{WIDTH{1'b0}}, op2};
                        neg_q <= 1'b0;
                    end
                    b_q <= op2;
                end else begin
                    res_q <= sc_res;
                    err_q <= ~onehot;
                end
            end else if (state == BUSY) begin
                acc   <= acc_nxt;
                a_q   <= a_nxt;
                mcand <= mcand << 1;
                cnt   <= cnt - 1'b1;
                if (cnt == '0) begin
                    res_q <= fin_res;
                    err_q <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// Random + directed bench for alu_mc; runs MUL_ITER=0 and MUL_ITER=1 instances side by side
// against a 64-bit arithmetic reference model.
module tb_alu_mc;
    localparam logic [15:0] C_ADD = 16'h0001, C_SUB = 16'h0002, C_SLT = 16'h0004,
        C_SLTU = 16'h0008, C_SLL = 16'h0010, C_SRL = 16'h0020, C_SRA = 16'h0040,
        C_AND = 16'h0080, C_OR = 16'h0100, C_XOR = 16'h0200, C_NOT = 16'h0400,
        C_MUL = 16'h0800, C_MULH = 16'h1000, C_DIV = 16'h2000, C_REM = 16'h4000;

    logic clk = 1'b0, rst = 1'b1;
    logic in_vld = 1'b0, out_rdy = 1'b1;
    logic [15:0] ctl = '0;
    logic [31:0] op1 = '0, op2 = '0;
    logic in_rdy0, out_vld0, err0, busy0, in_rdy1, out_vld1, err1, busy1;
    logic [31:0] res0, res1;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(32), .MUL_ITER(0)) u_dut0 (.clk(clk), .rst(rst), .in_vld(in_vld),
        .in_rdy(in_rdy0), .ctl(ctl), .op1(op1), .op2(op2), .out_vld(out_vld0),
        .out_rdy(out_rdy), .res(res0), .err(err0), .busy(busy0));
    alu_mc #(.WIDTH(32), .MUL_ITER(1)) u_dut1 (.clk(clk), .rst(rst), .in_vld(in_vld),
        .in_rdy(in_rdy1), .ctl(ctl), .op1(op1), .op2(op2), .out_vld(out_vld1),
        .out_rdy(out_rdy), .res(res1), .err(err1), .busy(busy1));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [15:0] c, input logic [31:0] a, input logic [31:0] b,
                                  input bit it, output logic [31:0] r, output logic e,
                                  output int lat);
        longint sa, sb, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = sa * sb;
        r = '0; e = 1'b0; lat = 1;
        case (c)
            C_ADD:  r = a + b;
            C_SUB:  r = a - b;
            C_SLT:  r = (sa < sb) ? 32'd1 : 32'd0;
            C_SLTU: r = (a < b) ? 32'd1 : 32'd0;
            C_SLL:  r = a << b[4:0];
            C_SRL:  r = a >> b[4:0];
            C_SRA:  r = 32'(sa >>> b[4:0]);
            C_AND:  r = a & b;
            C_OR:   r = a | b;
            C_XOR:  r = a ^ b;
            C_NOT:  r = ~a;
            C_MUL:  begin r = 32'(p);       lat = it ? 33 : 1; end
            C_MULH: begin r = 32'(p >>> 32); lat = it ? 33 : 1; end
            C_DIV:  begin r = (b == 0) ? 32'hFFFF_FFFF : a / b; lat = (b == 0) ? 1 : 33; end
            C_REM:  begin r = (b == 0) ? a : a % b;             lat = (b == 0) ? 1 : 33; end
            default: e = 1'b1;
        endcase
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!(in_rdy0 && in_rdy1) && n < 60) begin @(negedge clk); n++; end
        if (!(in_rdy0 && in_rdy1)) chk("rdy_timeout", 64'd0, 64'd1);
    endtask

    // Issue one op to both instances, collect each result and latency, compare to model.
    task automatic run_op(input logic [15:0] c, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r0, output logic [31:0] r1);
        logic [31:0] er0, er1;
        logic ee0, ee1, e0, e1;
        int el0, el1, lat0, lat1, bc0, bc1;
        bit g0, g1;
        @(negedge clk);
        wait_ready();
        model(c, a, b, 1'b0, er0, ee0, el0);
        model(c, a, b, 1'b1, er1, ee1, el1);
        ctl = c; op1 = a; op2 = b; in_vld = 1'b1; out_rdy = 1'b1;
        @(posedge clk); #1;
        in_vld = 1'b0; ctl = 16'($urandom); op1 = $urandom; op2 = $urandom;
        g0 = 0; g1 = 0; lat0 = 0; lat1 = 0; bc0 = 0; bc1 = 0;
        r0 = '0; r1 = '0; e0 = 1'b0; e1 = 1'b0;
        for (int t = 1; t <= 40 && !(g0 && g1); t++) begin
            @(negedge clk);
            if (busy0) bc0++;
            if (busy1) bc1++;
            if (!g0 && out_vld0) begin g0 = 1; lat0 = t; r0 = res0; e0 = err0; end
            if (!g1 && out_vld1) begin g1 = 1; lat1 = t; r1 = res1; e1 = err1; end
        end
        chk("lat0", 64'(lat0), 64'(el0));
        chk("res0", 64'(r0), 64'(er0));
        chk("err0", 64'(e0), 64'(ee0));
        chk("busy0", 64'(bc0), 64'(el0 - 1));
        chk("lat1", 64'(lat1), 64'(el1));
        chk("res1", 64'(r1), 64'(er1));
        chk("err1", 64'(e1), 64'(ee1));
        chk("busy1", 64'(bc1), 64'(el1 - 1));
    endtask

    initial begin
        logic [31:0] r0, r1, held;
        logic [15:0] ops [15];
        ops = '{C_ADD, C_SUB, C_SLT, C_SLTU, C_SLL, C_SRL, C_SRA, C_AND, C_OR, C_XOR,
                C_NOT, C_MUL, C_MULH, C_DIV, C_REM};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_vld", 64'(out_vld0), 64'd0);
        chk("rst_busy", 64'(busy1), 64'd0);
        chk("rst_res", 64'(res1), 64'd0);
        chk("rst_err", 64'(err0), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rdy_after_rst", 64'(in_rdy0 & in_rdy1), 64'd1);

        run_op(C_ADD, 32'h0097423B, 32'h014872C1, r0, r1);
        chk("spec_add", 64'(r0), 64'h01DFB4FC);
        run_op(C_DIV, 32'h0AE02023, 32'h00000010, r0, r1);
        chk("spec_div", 64'(r0), 64'h00AE0202);
        run_op(C_REM, 32'h0AE02023, 32'h00000010, r0, r1);
        chk("spec_rem", 64'(r1), 64'h00000003);
        run_op(C_DIV, 32'h55AA0001, 32'h0, r0, r1);
        chk("spec_div0", 64'(r0), 64'hFFFFFFFF);
        run_op(C_REM, 32'h00001234, 32'h0, r0, r1);
        chk("spec_rem0", 64'(r1), 64'h00001234);
        run_op(C_MULH, 32'h0012300F, 32'h8CBDA0FC, r0, r1);
        run_op(C_MULH, 32'h80000000, 32'h80000000, r0, r1);
        run_op(C_DIV, 32'hFFFFFFFF, 32'h00000001, r0, r1);
        run_op(C_SLL, 32'h00000001, 32'hFFFFFFFF, r0, r1);

        // Back-to-back AND then XOR, then a held result under backpressure.
        @(negedge clk); wait_ready();
        ctl = C_AND; op1 = 32'hF0F0_1234; op2 = 32'h0FF0_FF00; in_vld = 1'b1; out_rdy = 1'b1;
        @(posedge clk); #1;
        ctl = C_XOR; op1 = 32'hAAAA_5555; op2 = 32'h0F0F_0F0F;
        @(negedge clk);
        chk("b2b_vld1", 64'(out_vld0), 64'd1);
        chk("b2b_and", 64'(res0), 64'h00F0_1200);
        chk("b2b_rdy", 64'(in_rdy0), 64'd1);
        @(posedge clk); #1;
        in_vld = 1'b0;
        @(negedge clk);
        chk("b2b_vld2", 64'(out_vld0), 64'd1);
        chk("b2b_xor", 64'(res0), 64'hA5A5_5A5A);
        out_rdy = 1'b0;
        @(posedge clk); #1;
        held = res0;
        in_vld = 1'b1; ctl = C_OR; op1 = $urandom; op2 = $urandom;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("hold_res", 64'(res0), 64'(held));
            chk("hold_vld", 64'(out_vld0), 64'd1);
            chk("hold_rdy", 64'(in_rdy0), 64'd0);
        end
        in_vld = 1'b0; out_rdy = 1'b1;
        @(posedge clk); #1;
        chk("drain_vld", 64'(out_vld0), 64'd0);

        // Reset in the middle of a divide.
        @(negedge clk); wait_ready();
        ctl = C_DIV; op1 = 32'h12345678; op2 = 32'h00000123; in_vld = 1'b1;
        @(posedge clk); #1;
        in_vld = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_busy", 64'(busy0 | busy1), 64'd0);
        chk("rst_mid_vld", 64'(out_vld0 | out_vld1), 64'd0);
        @(negedge clk); rst = 1'b0;
        run_op(16'h0003, 32'h1, 32'h2, r0, r1);
        run_op(C_SRA, 32'h8012300F, 32'h00000007, r0, r1);
        chk("spec_sra", 64'(r0), 64'hFF002460);

        for (int i = 0; i < 40; i++) begin
            logic [15:0] c;
            logic [31:0] a, b;
            c = ops[$urandom_range(14)];
            if ($urandom_range(9) == 0) c = 16'($urandom);
            a = $urandom;
            b = $urandom;
            case ($urandom_range(3))
                0: b = b & 32'h0000_00FF;
                1: if ($urandom_range(3) == 0) b = '0;
                default: ;
            endcase
            run_op(c, a, b, r0, r1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
